// File: rtl/mux64_serializer_if.sv
// ---------------------------------------------------------------------------
// mux64_serializer_if
//   Bundles the parallel input handshake and the serial output handshake of
//   mux64_serializer.
//
//   Signals:
//     in_data   [63:0]  parallel word offered by the producer
//     in_valid          producer offers in_data
//     in_ready          serializer can capture a word
//     out_bit           current serial bit
//     out_sel   [5:0]   index of the bit currently on out_bit
//     out_valid         out_bit/out_sel/out_last are valid
//     out_ready         consumer accepts the current bit
//     out_last          current bit is the final bit of the word
//     busy              serializer is not idle
//
//   Modports:
//     master : the serializer itself (drives the serial stream and in_ready)
//     slave  : the environment (producer + serial consumer)
// ---------------------------------------------------------------------------
interface mux64_serializer_if;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_bit;
  logic [5:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_bit, out_sel, out_valid, out_last, busy
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_bit, out_sel, out_valid, out_last, busy
  );
endinterface

// File: rtl/mux64_serializer.sv
// ---------------------------------------------------------------------------
// mux64_serializer
//   Parallel-to-serial converter: captures a 64-bit word on the input
//   valid/ready handshake, then walks a 6-bit select counter across a 64:1
//   mux and presents one bit per accepted transfer on the output handshake.
//   The select index travels with each bit so a downstream 64-way demux can
//   route it directly.
//
//   Parameters:
//     MSB_FIRST  0: bit 0 first (sel 0..63); 1: bit 63 first (sel 63..0)
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     bus   mux64_serializer_if.master (in_data/in_valid/in_ready,
//           out_bit/out_sel/out_valid/out_ready/out_last, busy)
//
//   Build option:
//     MUX64_SERIALIZER_PARITY_EN  when defined, an extra even-parity bit
//     (out_sel=0) follows the 64 data bits and carries out_last instead of
//     the final data bit.
// ---------------------------------------------------------------------------
module mux64_serializer #(
  parameter int MSB_FIRST = 0
) (
  input  logic                clk,
  input  logic                rst,
  mux64_serializer_if.master  bus
);

`ifdef MUX64_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  localparam logic [5:0] SEL_FIRST = (MSB_FIRST != 0) ? 6'd63 : 6'd0;
  localparam logic [5:0] SEL_FINAL = (MSB_FIRST != 0) ? 6'd0  : 6'd63;

`ifdef MUX64_SERIALIZER_PARITY_EN
  function automatic logic even_parity(input logic [63:0] w);
    return ^w;
  endfunction
`endif

  state_t      state_q, state_d;
  logic [63:0] word_reg;
  logic [5:0]  sel;
  logic        load, step;

  logic        in_ready_c;
  logic        out_bit_c;
  logic [5:0]  out_sel_c;
  logic        out_valid_c;
  logic        out_last_c;
  logic        busy_c;

  // Next-state and output decode. Serial outputs depend only on state_q,
  // word_reg and sel, so nothing on the input side reaches them
  // combinationally; in_ready is additionally gated by rst so it reads 0
  // for the whole time reset is held.
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    step        = 1'b0;
    in_ready_c  = 1'b0;
    out_bit_c   = 1'b0;
    out_sel_c   = 6'd0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    busy_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_c = ~rst;
        if (bus.in_valid && !rst) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid_c = 1'b1;
        busy_c      = 1'b1;
        out_bit_c   = word_reg[sel];
        out_sel_c   = sel;
`ifndef MUX64_SERIALIZER_PARITY_EN
        out_last_c  = (sel == SEL_FINAL);
`endif
        if (bus.out_ready) begin
          if (sel == SEL_FINAL) begin
`ifdef MUX64_SERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end else begin
            step = 1'b1;
          end
        end
      end
`ifdef MUX64_SERIALIZER_PARITY_EN
      PARITY: begin
        out_valid_c = 1'b1;
        busy_c      = 1'b1;
        out_bit_c   = even_parity(word_reg);
        out_last_c  = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, captured word and select counter. The final select value always
  // leaves SHIFT, so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      word_reg <= '0;
      sel      <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        word_reg <= bus.in_data;
        sel      <= SEL_FIRST;
      end else if (step) begin
        sel <= (MSB_FIRST != 0) ? sel - 6'd1 : sel + 6'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_bit   = out_bit_c;
  assign bus.out_sel   = out_sel_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_mux64_serializer.sv
// ---------------------------------------------------------------------------
// tb_mux64_serializer
//   Scoreboard bench for mux64_serializer. Two instances are driven: one
//   LSB-first (index 0) and one MSB-first (index 1). Expected serial bits are
//   queued when a word is offered and popped by a per-instance monitor on
//   every accepted transfer.
// ---------------------------------------------------------------------------
module tb_mux64_serializer;

`ifdef MUX64_SERIALIZER_PARITY_EN
  localparam int NB = 65;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 64;
  localparam bit PAR = 1'b0;
`endif
  localparam int PERIOD = NB + 1;

  typedef struct {
    logic       b;
    logic [5:0] s;
    logic       l;
    logic       first;
    logic       data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;

  exp_t        sbq [2][$];
  int          firstq [2][$];
  int          xfers [2];
  logic [63:0] recon [2];
  logic        stall_prev [2];
  logic        prev_b [2];
  logic [5:0]  prev_s [2];
  logic        prev_l [2];
  logic        busy_chk [2];

  mux64_serializer_if bus_l ();
  mux64_serializer_if bus_m ();

  mux64_serializer #(.MSB_FIRST(0)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l));
  mux64_serializer #(.MSB_FIRST(1)) u_msb (.clk(clk), .rst(rst), .bus(bus_m));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output-side consumers: always ready, or pseudo-random stalls.
  always @(posedge clk) begin
    #1;
    bus_l.out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    bus_m.out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int k, input logic [63:0] w);
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      e.s     = (k == 1) ? 6'(63 - i) : 6'(i);
      e.b     = w[e.s];
      e.l     = (i == 63) && !PAR;
      e.first = (i == 0);
      e.data  = 1'b1;
      sbq[k].push_back(e);
    end
    if (PAR) begin
      e.s = 6'd0; e.b = ^w; e.l = 1'b1; e.first = 1'b0; e.data = 1'b0;
      sbq[k].push_back(e);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic r, input logic b,
                     input logic [5:0] s, input logic l, input logic bz, input logic ir);
    exp_t e;
    if (stall_prev[k]) begin
      chk("hold_bit", b, prev_b[k]);
      chk("hold_sel", s, prev_s[k]);
      chk("hold_last", l, prev_l[k]);
    end
    if (busy_chk[k]) begin
      chk("busy_fall", bz, 1'b0);
      chk("ready_after_word", ir, 1'b1);
    end
    busy_chk[k] = 1'b0;
    if (v) chk("ready_while_shift", ir, 1'b0);
    stall_prev[k] = v && !r;
    prev_b[k] = b; prev_s[k] = s; prev_l[k] = l;
    if (v && r) begin
      if (sbq[k].size() == 0) begin
        chk("unexpected_xfer", 1'b1, 1'b0);
      end else begin
        e = sbq[k].pop_front();
        chk("bit", b, e.b);
        chk("sel", s, e.s);
        chk("last", l, e.l);
        if (e.first) firstq[k].push_back(cyc);
        if (e.data) recon[k][s] = b;
        xfers[k]++;
        if (e.l) busy_chk[k] = 1'b1;
      end
    end
  endtask

  always @(negedge clk)
    if (!rst) mon(0, bus_l.out_valid, bus_l.out_ready, bus_l.out_bit, bus_l.out_sel,
                  bus_l.out_last, bus_l.busy, bus_l.in_ready);
  always @(negedge clk)
    if (!rst) mon(1, bus_m.out_valid, bus_m.out_ready, bus_m.out_bit, bus_m.out_sel,
                  bus_m.out_last, bus_m.busy, bus_m.in_ready);

  task automatic set_in(input int k, input logic [63:0] w, input logic v);
    if (k == 0) begin bus_l.in_data = w; bus_l.in_valid = v; end
    else        begin bus_m.in_data = w; bus_m.in_valid = v; end
  endtask

  // Waits for the handshake; returns just after the capturing edge.
  task automatic wait_capture(input int k);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if ((k == 0) ? bus_l.in_ready : bus_m.in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("capture_timeout", 1'b1, 1'b0);
  endtask

  task automatic send_word(input int k, input logic [63:0] w);
    push_exp(k, w);
    set_in(k, w, 1'b1);
    wait_capture(k);
    set_in(k, 64'd0, 1'b0);
  endtask

  task automatic drain(input int k, input int nwords);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sbq[k].size() == 0 && !((k == 0) ? bus_l.busy : bus_m.busy)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_done", ok, 1'b1);
    chk("xfer_count", xfers[k], nwords * NB);
    xfers[k] = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic found;
    for (int k = 0; k < 2; k++) begin
      xfers[k] = 0; recon[k] = '0; stall_prev[k] = 1'b0; busy_chk[k] = 1'b0;
      prev_b[k] = 1'b0; prev_s[k] = 6'd0; prev_l[k] = 1'b0;
    end
    rst = 1'b1;
    set_in(0, 64'd0, 1'b0);
    set_in(1, 64'd0, 1'b0);
    #3;
    chk("rst_in_ready", bus_l.in_ready, 1'b0);
    chk("rst_out_valid", bus_l.out_valid, 1'b0);
    chk("rst_busy", bus_l.busy, 1'b0);
    chk("rst_out_sel", bus_m.out_sel, 6'd0);
    chk("rst_out_bit", bus_l.out_bit, 1'b0);
    chk("rst_out_last", bus_m.out_last, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready_l", bus_l.in_ready, 1'b1);
    chk("idle_in_ready_m", bus_m.in_ready, 1'b1);

    // Single bit set, LSB first.
    send_word(0, 64'h0000_0000_0000_0001);
    drain(0, 1);

    // Top bit set, MSB first.
    send_word(1, 64'h8000_0000_0000_0000);
    drain(1, 1);

    // Mixed pattern with random back-pressure on both orders.
    rdy_mode = 1;
    recon[0] = '0;
    recon[1] = '0;
    send_word(0, 64'hA5A5_5A5A_F0F0_0F0F);
    drain(0, 1);
    chk("recon_lsb", recon[0], 64'hA5A5_5A5A_F0F0_0F0F);
    send_word(1, 64'hA5A5_5A5A_F0F0_0F0F);
    drain(1, 1);
    chk("recon_msb", recon[1], 64'hA5A5_5A5A_F0F0_0F0F);
    rdy_mode = 0;

    // Reset asserted mid-word at sel 20.
    send_word(0, 64'h0123_4567_89AB_CDEF);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_l.out_valid && bus_l.out_sel == 6'd20) begin
        found = 1'b1;
        break;
      end
    end
    chk("sel20_reached", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus_l.out_valid, 1'b0);
    chk("midrst_busy", bus_l.busy, 1'b0);
    chk("midrst_in_ready", bus_l.in_ready, 1'b0);
    chk("midrst_out_sel", bus_l.out_sel, 6'd0);
    sbq[0].delete();
    stall_prev[0] = 1'b0;
    busy_chk[0] = 1'b0;
    xfers[0] = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus_l.in_ready, 1'b1);
    send_word(0, 64'hFFFF_FFFF_FFFF_FFFF);
    drain(0, 1);

    // Back-to-back words with in_valid held high.
    firstq[0].delete();
    push_exp(0, 64'h1);
    set_in(0, 64'h1, 1'b1);
    wait_capture(0);
    push_exp(0, 64'h2);
    set_in(0, 64'h2, 1'b1);
    wait_capture(0);
    set_in(0, 64'd0, 1'b0);
    drain(0, 2);
    if (firstq[0].size() == 2) chk("first_bit_spacing", firstq[0][1] - firstq[0][0], PERIOD);
    else chk("first_bit_count", firstq[0].size(), 2);

    // Parity-relevant patterns (plain data patterns in the default build).
    send_word(0, 64'h7);
    drain(0, 1);
    send_word(1, 64'h3);
    drain(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
